// File: rtl/barrel_shifter_right_pipe.sv
// barrel_shifter_right_pipe
//
// Pipelined 32-bit right barrel shifter with valid/ready flow control.
// Five register stages each apply one power-of-two shift, selected by
// one ShiftAmount bit: 16, 8, 4, 2, then 1. Vacated MSBs take ShiftIn.
// The result is {{n{ShiftIn}}, In[31:n]} for n = ShiftAmount.
//
// Ports:
//   Clock        rising-edge clock
//   Reset        synchronous active-high reset; drops all in-flight entries
//   In           operand
//   ShiftAmount  right-shift distance 0..31
//   ShiftIn      fill bit for the vacated MSBs
//   InValid      In/ShiftAmount/ShiftIn are valid
//   InReady      operand accepted this cycle when InValid is also high
//   Out          shifted result (last stage register)
//   OutValid     Out holds a result
//   OutReady     consumer takes Out this cycle
//   Busy         at least one stage holds a valid entry
module barrel_shifter_right_pipe #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [WIDTH-1:0]   In,
  input  logic [SHAMT_W-1:0] ShiftAmount,
  input  logic               ShiftIn,
  input  logic               InValid,
  output logic               InReady,
  output logic [WIDTH-1:0]   Out,
  output logic               OutValid,
  input  logic               OutReady,
  output logic               Busy
);

  localparam int STAGES = SHAMT_W;
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  // Stage registers. The last stage only needs data and valid: its shift
  // bit and fill bit are consumed while loading it.
  logic [WIDTH-1:0]   dataReg  [STAGES];
  logic [STAGES-1:0]  validReg;
  logic [SHAMT_W-1:0] amtReg   [STAGES-1];
  logic               fillReg  [STAGES-1];

  // Source of each stage: the inputs for S1, the previous stage otherwise.
  logic [WIDTH-1:0]   upData   [STAGES];
  logic [SHAMT_W-1:0] upAmt    [STAGES];
  logic               upFill   [STAGES];
  logic [STAGES-1:0]  upValid;

  logic [WIDTH-1:0]   nextData [STAGES];
  logic [STAGES-1:0]  advance;
  logic               fullFromHere;

  always_comb begin : sourceSelect
    upData[0]  = In;
    upAmt[0]   = ShiftAmount;
    upFill[0]  = ShiftIn;
    upValid[0] = InValid;
    for (int i = 1; i < STAGES; i++) begin
      upData[i]  = dataReg[i-1];
      upAmt[i]   = amtReg[i-1];
      upFill[i]  = fillReg[i-1];
      upValid[i] = validReg[i-1];
    end
  end

  // One 2:1 mux per stage. Stage gi handles ShiftAmount bit (SHAMT_W-1-gi),
  // so the largest distance is applied first.
  for (genvar gi = 0; gi < STAGES; gi++) begin : gStage
    localparam int DIST = 1 << (SHAMT_W - 1 - gi);
    logic [WIDTH-1:0] fillMask;
    assign fillMask     = upFill[gi] ? ~(ALL_ONES >> DIST) : '0;
    assign nextData[gi] = upAmt[gi][SHAMT_W-1-gi]
                        ? ((upData[gi] >> DIST) | fillMask)
                        : upData[gi];
  end

  // A stage advances unless it and every stage after it are full while the
  // consumer stalls. This is the unrolled form of
  // en(i) = !valid(i) || en(i+1), en(last+1) = OutReady, written without a
  // self-referencing vector so the chain stays a simple combinational scan.
  always_comb begin : enableChain
    fullFromHere = 1'b1;
    advance      = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      fullFromHere = fullFromHere & validReg[i];
      advance[i]   = OutReady | ~fullFromHere;
    end
  end

  always_ff @(posedge Clock) begin : stageCtrl
    if (Reset) begin
      validReg <= '0;
      for (int i = 0; i < STAGES; i++) begin
        dataReg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (advance[i]) begin
          validReg[i] <= upValid[i];
          dataReg[i]  <= nextData[i];
        end
      end
    end
  end

  // Shift bits and fill are don't-care while a stage is invalid, so they
  // carry no reset.
  always_ff @(posedge Clock) begin : stageSide
    for (int i = 0; i < STAGES - 1; i++) begin
      if (advance[i]) begin
        amtReg[i]  <= upAmt[i];
        fillReg[i] <= upFill[i];
      end
    end
  end

  assign InReady  = advance[0];
  assign Out      = dataReg[STAGES-1];
  assign OutValid = validReg[STAGES-1];
  assign Busy     = |validReg;

endmodule

// File: tb/tb_barrel_shifter_right_pipe.sv
// Testbench for barrel_shifter_right_pipe: scoreboard queue filled by the
// driver on each input transfer, drained by an output monitor process.
module tb_barrel_shifter_right_pipe;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] In;
  logic [4:0]  ShiftAmount;
  logic        ShiftIn;
  logic        InValid;
  logic        InReady;
  logic [31:0] Out;
  logic        OutValid;
  logic        OutReady;
  logic        Busy;

  always #5 Clock = ~Clock;

  barrel_shifter_right_pipe #(.WIDTH(32), .SHAMT_W(5)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .In          (In),
    .ShiftAmount (ShiftAmount),
    .ShiftIn     (ShiftIn),
    .InValid     (InValid),
    .InReady     (InReady),
    .Out         (Out),
    .OutValid    (OutValid),
    .OutReady    (OutReady),
    .Busy        (Busy)
  );

  logic [31:0] expQ[$];
  int          checkCount  = 0;
  int          passCount   = 0;
  int          outCount    = 0;
  bit          randomReady = 1'b0;
  bit          lastStalled = 1'b0;
  logic [31:0] lastOut     = '0;

  // Reference: fill-extend to 64 bits and shift arithmetically.
  function automatic logic [31:0] refShift(logic [31:0] d, logic [4:0] n, logic f);
    logic [63:0] ext;
    ext = {{32{f}}, d};
    ext = ext >> n;
    return ext[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    if (randomReady) OutReady = 1'($urandom_range(0, 1));
  endtask

  // One cycle of input drive; pushes the expected result if a transfer occurs.
  task automatic driveCycle(input logic v, input logic [31:0] d, input logic [4:0] n,
                            input logic f, input logic [31:0] exp, output bit accepted);
    InValid     = v;
    In          = d;
    ShiftAmount = n;
    ShiftIn     = f;
    @(negedge Clock);
    accepted = v && InReady;
    if (accepted) expQ.push_back(exp);
    tick();
  endtask

  task automatic sendOp(input logic [31:0] d, input logic [4:0] n, input logic f,
                        input logic [31:0] exp, output int waited);
    bit acc;
    waited = 0;
    acc    = 1'b0;
    while (!acc) begin
      driveCycle(1'b1, d, n, f, exp, acc);
      if (!acc) begin
        waited++;
        if (waited > 200) begin
          checkCount++;
          $display("FAIL send_timeout: InReady stayed 0 for %0d cycles, required 1", waited);
          break;
        end
      end
    end
    InValid = 1'b0;
  endtask

  task automatic sendRandom(output int waited);
    logic [31:0] d;
    logic [4:0]  n;
    logic        f;
    d = $urandom;
    n = 5'($urandom_range(0, 31));
    f = 1'($urandom_range(0, 1));
    sendOp(d, n, f, refShift(d, n, f), waited);
  endtask

  task automatic drain();
    int k;
    randomReady = 1'b0;
    OutReady    = 1'b1;
    InValid     = 1'b0;
    k = 0;
    while (k < 50) begin
      @(negedge Clock);
      if (!Busy) break;
      tick();
      k++;
    end
    check("drain_busy", 32'(Busy), 32'd0);
    check("drain_queue_empty", 32'(expQ.size()), 32'd0);
    tick();
  endtask

  // Output monitor: pops the scoreboard on every output transfer and checks
  // that a stalled output holds its value.
  initial begin : outMonitor
    logic [31:0] exp;
    forever begin
      @(negedge Clock);
      if (Reset) begin
        lastStalled = 1'b0;
      end else begin
        if (lastStalled) begin
          checkCount++;
          if (OutValid === 1'b1 && Out === lastOut) passCount++;
          else $display("FAIL stall_hold: Out=%h OutValid=%b, required Out=%h OutValid=1",
                        Out, OutValid, lastOut);
        end
        if (OutValid && OutReady) begin
          checkCount++;
          if (expQ.size() == 0) begin
            $display("FAIL unexpected_output: got %h with empty scoreboard, required no output", Out);
          end else begin
            exp = expQ.pop_front();
            if (Out === exp) begin
              passCount++;
              $display("out %h exp %h ok", Out, exp);
            end else begin
              $display("FAIL result: got %h, required %h", Out, exp);
            end
          end
          outCount++;
        end
        lastStalled = OutValid && !OutReady;
        lastOut     = Out;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : mainSeq
    int  waited;
    int  stalls;
    int  lat;
    int  startCount;
    int  idx;
    int  lowCycles;
    bit  acc;
    logic [31:0] bpData [8];
    logic [4:0]  bpAmt  [8];
    logic        bpFill [8];

    Reset = 1'b1; In = '0; ShiftAmount = '0; ShiftIn = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    repeat (3) tick();
    Reset = 1'b0;
    @(negedge Clock);
    check("reset_out", Out, 32'h0);
    check("reset_outvalid", 32'(OutValid), 32'd0);
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_inready", 32'(InReady), 32'd1);
    tick();

    // Directed cases, first one also measures latency.
    sendOp(32'h8000_0001, 5'd1, 1'b0, 32'h4000_0000, waited);
    lat = 0;
    do begin
      lat++;
      @(negedge Clock);
    end while (!OutValid && lat < 10);
    check("latency_negedges", 32'(lat), 32'd5);
    tick();
    sendOp(32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, waited);
    sendOp(32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF, waited);
    sendOp(32'hDEAD_BEEF, 5'd16, 1'b0, 32'h0000_DEAD, waited);
    sendOp(32'h0000_00F0, 5'd4,  1'b1, 32'hF000_000F, waited);
    drain();

    // Streaming: 100 back-to-back operands with OutReady held high.
    startCount = outCount;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      sendRandom(waited);
      stalls += waited;
    end
    check("stream_inready_stalls", 32'(stalls), 32'd0);
    drain();
    check("stream_output_count", 32'(outCount - startCount), 32'd100);

    // Backpressure: OutReady low for cycles 2..7 while streaming 8 operands.
    for (int i = 0; i < 8; i++) begin
      bpData[i] = $urandom;
      bpAmt[i]  = 5'($urandom_range(0, 31));
      bpFill[i] = 1'($urandom_range(0, 1));
    end
    startCount = outCount;
    idx = 0;
    lowCycles = 0;
    for (int c = 0; c < 60 && idx < 8; c++) begin
      OutReady = (c >= 2 && c < 8) ? 1'b0 : 1'b1;
      driveCycle(1'b1, bpData[idx], bpAmt[idx], bpFill[idx],
                 refShift(bpData[idx], bpAmt[idx], bpFill[idx]), acc);
      if (!acc) lowCycles++;
      if (acc) idx++;
    end
    InValid = 1'b0;
    check("bp_all_accepted", 32'(idx), 32'd8);
    check("bp_inready_low_cycles", 32'(lowCycles), 32'd3);
    drain();
    check("bp_output_count", 32'(outCount - startCount), 32'd8);

    // Bubbles with random OutReady.
    randomReady = 1'b1;
    for (int i = 0; i < 40; i++) begin
      sendRandom(waited);
      driveCycle(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, acc);
    end
    drain();

    // Reset with three entries in flight.
    OutReady = 1'b1;
    for (int i = 0; i < 3; i++) sendRandom(waited);
    Reset = 1'b1;
    InValid = 1'b0;
    tick();
    Reset = 1'b0;
    expQ.delete();
    startCount = outCount;
    @(negedge Clock);
    check("midreset_outvalid", 32'(OutValid), 32'd0);
    check("midreset_busy", 32'(Busy), 32'd0);
    check("midreset_out", Out, 32'h0);
    check("midreset_inready", 32'(InReady), 32'd1);
    tick();
    repeat (10) tick();
    check("midreset_no_stale", 32'(outCount - startCount), 32'd0);

    // A few more operands after reset to confirm normal service.
    for (int i = 0; i < 10; i++) sendRandom(waited);
    drain();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
